// File: rtl/hazard_ctrl_if.sv
// D-stage hazard interface: decoder-side Tuse/Tnew/register info in, stall and
// forwarding selects out.
interface hazard_ctrl_if;
  logic       need_rs_D, need_rt_D;
  logic [2:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic [4:0] rs_D, rt_D, A3_D;
  logic [1:0] md_op_D;
  logic       md_use_D;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic       fwd_rt_M;
  logic       md_busy;

  modport master (
    output need_rs_D, need_rt_D, Tuse_rs_D, Tuse_rt_D, Tnew_D,
           rs_D, rt_D, A3_D, md_op_D, md_use_D, flush,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy
  );
  modport slave (
    input  need_rs_D, need_rt_D, Tuse_rs_D, Tuse_rt_D, Tnew_D,
           rs_D, rt_D, A3_D, md_op_D, md_use_D, flush,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: keeps E/M/W destination records,
// produces the D stall, D/E/M forwarding selects and the mult/div busy window.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  hazard_ctrl_if.slave hz
);
  localparam logic [1:0] MD_NONE  = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef struct packed {
    logic [4:0] rs, rt, a3;
    logic [2:0] tnew;
    logic [1:0] md;
  } e_rec_t;

  typedef struct packed {
    logic [4:0] rt, a3;
    logic [2:0] tnew;
  } m_rec_t;

  e_rec_t     rec_e, rec_e_d;
  m_rec_t     rec_m, rec_m_d;
  logic [4:0] a3_w;
  logic [3:0] cnt;
  logic       stall, md_busy;

  function automatic logic hit(input logic [4:0] r, input logic [4:0] a3);
    return (r != 5'd0) && (r == a3);
  endfunction

  function automatic logic dep(input logic need, input logic [4:0] r, input logic [2:0] tuse,
                               input e_rec_t e, input m_rec_t m);
    return need && ((hit(r, e.a3) && (e.tnew > tuse)) || (hit(r, m.a3) && (m.tnew > tuse)));
  endfunction

  // Youngest match wins; a not-yet-ready younger producer masks older ones (stall covers it)
  function automatic logic [1:0] fwd_d(input logic [4:0] r, input e_rec_t e, input m_rec_t m,
                                       input logic [4:0] w);
    if (hit(r, e.a3)) return (e.tnew == 3'd0) ? 2'b11 : 2'b00;
    if (hit(r, m.a3)) return (m.tnew == 3'd0) ? 2'b10 : 2'b00;
    return hit(r, w) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] r, input m_rec_t m, input logic [4:0] w);
    if (hit(r, m.a3) && (m.tnew == 3'd0)) return 2'b10;
    return hit(r, w) ? 2'b01 : 2'b00;
  endfunction

  always_comb begin
    md_busy = (rec_e.md != MD_NONE) || (cnt != 4'd0);
    stall   = dep(hz.need_rs_D, hz.rs_D, hz.Tuse_rs_D, rec_e, rec_m) |
              dep(hz.need_rt_D, hz.rt_D, hz.Tuse_rt_D, rec_e, rec_m) |
              (hz.md_use_D & md_busy);
  end

  assign hz.stall    = stall;
  assign hz.md_busy  = md_busy;
  assign hz.fwd_rs_D = fwd_d(hz.rs_D, rec_e, rec_m, a3_w);
  assign hz.fwd_rt_D = fwd_d(hz.rt_D, rec_e, rec_m, a3_w);
  assign hz.fwd_rs_E = fwd_e(rec_e.rs, rec_m, a3_w);
  assign hz.fwd_rt_E = fwd_e(rec_e.rt, rec_m, a3_w);
  assign hz.fwd_rt_M = hit(rec_m.rt, a3_w);

  always_comb begin
    rec_e_d      = '0;
    rec_e_d.rs   = hz.rs_D;
    rec_e_d.rt   = hz.rt_D;
    rec_e_d.a3   = hz.A3_D;
    rec_e_d.tnew = hz.Tnew_D;
    rec_e_d.md   = (hz.md_op_D == 2'b11) ? MD_NONE : hz.md_op_D;
    rec_m_d      = '0;
    rec_m_d.rt   = rec_e.rt;
    rec_m_d.a3   = rec_e.a3;
    rec_m_d.tnew = (rec_e.tnew == 3'd0) ? 3'd0 : rec_e.tnew - 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rec_e <= '0;
      rec_m <= '0;
      a3_w  <= '0;
    end else if (hz.flush) begin
      rec_e <= '0;
      rec_m <= '0;
      a3_w  <= '0;
    end else begin
      rec_e <= stall ? '0 : rec_e_d;
      rec_m <= rec_m_d;
      a3_w  <= rec_m.a3;
    end
  end

  // A flushed mult/div never starts, but a count already running keeps draining
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              cnt <= '0;
    else if (!hz.flush && rec_e.md == MD_MULT) cnt <= MULT_CNT;
    else if (!hz.flush && rec_e.md == MD_DIV)  cnt <= DIV_CNT;
    else if (cnt != 4'd0)                      cnt <= cnt - 4'd1;
  end
endmodule
